// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared constants and types for the block-RAM port arbiter
package ram_port_arbiter_pkg;

    localparam int          RAM_ADDR_W    = 6;
    localparam int          RAM_DATA_W    = 32;
    localparam int          RAM_DEPTH     = 1 << RAM_ADDR_W;
    localparam logic [31:0] RAM_CLEAR_VAL = 32'h0000_0000;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // One entry of the read-tracking pipe: id is the requester that owns the read.
    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - one requester's request/response bundle
interface ram_port_arbiter_if
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
);

    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// rtl/ram_port_arbiter_rr_arb2.sv - two-requester round-robin grant, one-hot, combinational
module ram_port_arbiter_rr_arb2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        // On contention the requester that did not win last time goes first.
        if (valid0 && valid1) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = {valid1, valid0};
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - clears the single-port RAM after reset, then arbitrates two requesters onto it
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int                ADDR_W    = RAM_ADDR_W,
    parameter int                DATA_W    = RAM_DATA_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL = DATA_W'(RAM_CLEAR_VAL)
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_port_arbiter_if.slave    req0,
    ram_port_arbiter_if.slave    req1,
    output logic                 ram_we,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [DATA_W-1:0]    ram_din,
    input  logic [DATA_W-1:0]    ram_dout,
    output logic                 init_done
);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W:0]   sweep_cnt;
    logic              last_grant;
    logic [1:0]        grant;
    logic              run;
    logic              accept;
    logic              sel;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    tag_t              tag_s1_nx;
    tag_t              tag_s1;
    tag_t              tag_s2;

    assign run = (state == ST_RUN);

    ram_port_arbiter_rr_arb2 u_rr_arb2 (
        .valid0     (req0.valid & run),
        .valid1     (req1.valid & run),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign req0.ready = grant[0];
    assign req1.ready = grant[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        sel       = grant[1];
        sel_we    = sel ? req1.we    : req0.we;
        sel_addr  = sel ? req1.addr  : req0.addr;
        sel_wdata = sel ? req1.wdata : req0.wdata;
        case (state)
            // sweep_cnt MSB sets once the last address has been driven onto the RAM
            ST_INIT: if (sweep_cnt[ADDR_W]) state_nx = ST_RUN;
            ST_RUN:  accept = |grant;
            default: state_nx = ST_INIT;
        endcase
        tag_s1_nx.valid = accept & ~sel_we;
        tag_s1_nx.id    = sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sweep_cnt      <= '0;
            ram_we         <= 1'b0;
            ram_addr       <= '0;
            ram_din        <= '0;
            init_done      <= 1'b0;
            last_grant     <= 1'b1;
            tag_s1         <= '0;
            tag_s2         <= '0;
            req0.rsp_valid <= 1'b0;
            req1.rsp_valid <= 1'b0;
            req0.rsp_rdata <= '0;
            req1.rsp_rdata <= '0;
        end else begin
            tag_s1 <= tag_s1_nx;
            tag_s2 <= tag_s1;

            // Stage 2 lines up with ram_dout; capture and strobe the owning port.
            req0.rsp_valid <= tag_s2.valid & ~tag_s2.id;
            req1.rsp_valid <= tag_s2.valid &  tag_s2.id;
            if (tag_s2.valid && !tag_s2.id) req0.rsp_rdata <= ram_dout;
            if (tag_s2.valid &&  tag_s2.id) req1.rsp_rdata <= ram_dout;

            if (state == ST_INIT) begin
                if (sweep_cnt[ADDR_W]) begin
                    ram_we    <= 1'b0;
                    init_done <= 1'b1;
                end else begin
                    ram_we    <= 1'b1;
                    ram_addr  <= sweep_cnt[ADDR_W-1:0];
                    ram_din   <= CLEAR_VAL;
                    sweep_cnt <= sweep_cnt + 1'b1;
                end
            end else begin
                ram_we <= accept & sel_we;
                if (accept) begin
                    ram_addr   <= sel_addr;
                    last_grant <= sel;
                    if (sel_we) ram_din <= sel_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter with a behavioural RAM
module tb_ram_port_arbiter;
    import ram_port_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fill = 1'b0;
    logic        ram_we;
    logic [5:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        init_done;
    logic [31:0] mem [RAM_DEPTH];

    int passed = 0;
    int failed = 0;
    int total  = 0;

    ram_port_arbiter_if req0_if ();
    ram_port_arbiter_if req1_if ();

    ram_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0_if),
        .req1      (req1_if),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    // Single-port RAM, registered read; fill loads garbage so the clear sweep is visible.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < RAM_DEPTH; i++) mem[i] <= 32'hBAD0_0000 | 32'(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    function automatic logic [43:0] vec();
        return {ram_we, ram_addr, ram_din, init_done, req0_if.ready, req1_if.ready,
                req0_if.rsp_valid, req1_if.rsp_valid};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic we, input logic [5:0] a, input logic [31:0] d);
        req0_if.valid = v; req0_if.we = we; req0_if.addr = a; req0_if.wdata = d;
    endtask

    task automatic drive1(input logic v, input logic we, input logic [5:0] a, input logic [31:0] d);
        req1_if.valid = v; req1_if.we = we; req1_if.addr = a; req1_if.wdata = d;
    endtask

    task automatic sweep_checks(input int n, input logic r1_valid);
        for (int i = 0; i < n; i++) begin
            tick();
            check("sweep", 64'(vec()), 64'({1'b1, 6'(i), 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        end
        if (r1_valid) check("sweep_r1_valid", 64'(req1_if.valid), 64'(1'b1));
    endtask

    initial begin
        logic [5:0] a0 [3];
        logic [5:0] a1 [3];
        logic [5:0] pre [6];
        int i0;
        int i1;
        int k;

        a0 = '{6'd1, 6'd2, 6'd3};
        a1 = '{6'd9, 6'd10, 6'd11};
        pre = '{6'd1, 6'd2, 6'd3, 6'd9, 6'd10, 6'd11};

        drive0(1'b1, 1'b0, 6'h0, 32'h0);
        drive1(1'b0, 1'b0, 6'h0, 32'h0);
        fill = 1'b1;
        tick();
        tick();
        fill = 1'b0;
        check("reset_outs", 64'(vec()), 64'(0));
        check("reset_rdata", 64'({req0_if.rsp_rdata, req1_if.rsp_rdata}), 64'(0));
        drive0(1'b0, 1'b0, 6'h0, 32'h0);

        // Clear sweep: 64 writes, init_done on cycle 65
        rst = 1'b0;
        sweep_checks(RAM_DEPTH, 1'b0);
        tick();
        check("init_done", 64'({ram_we, init_done, req0_if.ready, req1_if.ready}), 64'(4'b0100));

        // Read of a cleared address, 3-cycle latency
        drive0(1'b1, 1'b0, 6'h2A, 32'h0);
        #1;
        check("rd2a_ready", 64'({req1_if.ready, req0_if.ready}), 64'(2'b01));
        tick();
        drive0(1'b0, 1'b0, 6'h0, 32'h0);
        check("rd2a_issue", 64'({ram_we, ram_addr}), 64'({1'b0, 6'h2A}));
        tick();
        check("rd2a_early", 64'({req0_if.rsp_valid, req1_if.rsp_valid}), 64'(2'b00));
        tick();
        check("rd2a_rsp", 64'({req0_if.rsp_valid, req0_if.rsp_rdata}), 64'({1'b1, 32'h0}));
        tick();
        check("rd2a_strobe", 64'(req0_if.rsp_valid), 64'(1'b0));

        // Write then read-after-write on the next cycle
        drive0(1'b1, 1'b1, 6'd5, 32'hDEAD_BEEF);
        #1;
        check("wr5_ready", 64'({req1_if.ready, req0_if.ready}), 64'(2'b01));
        tick();
        check("wr5_issue", 64'({ram_we, ram_addr, ram_din}), 64'({1'b1, 6'd5, 32'hDEAD_BEEF}));
        drive0(1'b1, 1'b0, 6'd5, 32'h0);
        #1;
        check("rd5_ready", 64'({req1_if.ready, req0_if.ready}), 64'(2'b01));
        tick();
        drive0(1'b0, 1'b0, 6'h0, 32'h0);
        check("rd5_issue", 64'({ram_we, ram_addr, ram_din}), 64'({1'b0, 6'd5, 32'hDEAD_BEEF}));
        tick();
        check("wr5_norsp", 64'({req0_if.rsp_valid, req1_if.rsp_valid}), 64'(2'b00));
        tick();
        check("rd5_rsp", 64'({req0_if.rsp_valid, req1_if.rsp_valid, req0_if.rsp_rdata}),
              64'({1'b1, 1'b0, 32'hDEAD_BEEF}));

        // Preload through req1, leaving last_grant on requester 1
        for (int i = 0; i < 6; i++) begin
            drive1(1'b1, 1'b1, pre[i], 32'hA000_0000 | 32'(pre[i]));
            tick();
        end
        drive1(1'b0, 1'b0, 6'h0, 32'h0);
        tick();
        tick();

        // Contention: grants alternate starting with requester 0
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 8; c++) begin
            drive0(i0 < 3, 1'b0, (i0 < 3) ? a0[i0] : 6'h0, 32'h0);
            drive1(i1 < 3, 1'b0, (i1 < 3) ? a1[i1] : 6'h0, 32'h0);
            #1;
            if (c < 6) check("arb_grant", 64'({req1_if.ready, req0_if.ready}),
                             64'(((c % 2) == 0) ? 2'b01 : 2'b10));
            tick();
            if (c < 6) begin
                if ((c % 2) == 0) i0++;
                else i1++;
            end
            if (c >= 2) begin
                k = c - 2;
                if ((k % 2) == 0)
                    check("arb_rsp0", 64'({req0_if.rsp_valid, req1_if.rsp_valid, req0_if.rsp_rdata}),
                          64'({2'b10, 32'hA000_0000 | 32'(a0[k / 2])}));
                else
                    check("arb_rsp1", 64'({req0_if.rsp_valid, req1_if.rsp_valid, req1_if.rsp_rdata}),
                          64'({2'b01, 32'hA000_0000 | 32'(a1[k / 2])}));
            end else begin
                check("arb_norsp", 64'({req0_if.rsp_valid, req1_if.rsp_valid}), 64'(2'b00));
            end
        end
        tick();
        check("arb_end", 64'({req0_if.rsp_valid, req1_if.rsp_valid}), 64'(2'b00));

        // req1 back-to-back burst
        for (int i = 0; i < 4; i++) begin
            drive0(1'b1, 1'b1, 6'(i), 32'h10 + 32'(i));
            tick();
        end
        drive0(1'b0, 1'b0, 6'h0, 32'h0);
        for (int b = 0; b < 6; b++) begin
            drive1(b < 4, 1'b0, 6'(b), 32'h0);
            #1;
            if (b < 4) check("burst_ready", 64'(req1_if.ready), 64'(1'b1));
            tick();
            if (b >= 2)
                check("burst_rsp", 64'({req1_if.rsp_valid, req0_if.rsp_valid, req1_if.rsp_rdata}),
                      64'({2'b10, 32'h10 + 32'(b - 2)}));
        end
        tick();
        check("burst_end", 64'(req1_if.rsp_valid), 64'(1'b0));

        // Reset with a read in flight; req1 waits through the new sweep
        drive0(1'b1, 1'b0, 6'd7, 32'h0);
        tick();
        drive0(1'b0, 1'b0, 6'h0, 32'h0);
        check("pre_rst_addr", 64'(ram_addr), 64'(6'd7));
        rst = 1'b1;
        drive1(1'b1, 1'b0, 6'd3, 32'h0);
        #1;
        check("rst_async", 64'(vec()), 64'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_norsp", 64'({req0_if.rsp_valid, req1_if.rsp_valid}), 64'(2'b00));
        end
        rst = 1'b0;
        sweep_checks(10, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_midsweep", 64'({ram_we, ram_addr, init_done}), 64'(0));
        tick();
        rst = 1'b0;
        sweep_checks(RAM_DEPTH, 1'b1);
        tick();
        check("init2_accept", 64'({ram_we, init_done, req0_if.ready, req1_if.ready}), 64'(4'b0101));
        tick();
        drive1(1'b0, 1'b0, 6'h0, 32'h0);
        check("init2_issue", 64'({ram_we, ram_addr}), 64'({1'b0, 6'd3}));
        tick();
        tick();
        check("init2_rsp", 64'({req1_if.rsp_valid, req0_if.rsp_valid, req1_if.rsp_rdata}),
              64'({2'b10, 32'h0}));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
